// File: rtl/axi_fifo_pkt_arb.sv
// Packet-granular round-robin arbiter that feeds one FIFO write port from NUM_PORTS streams.
// A port is granted only when the FIFO can take a worst-case packet, and keeps the grant until tlast.
module axi_fifo_pkt_arb #(
   parameter int WIDTH     = 32,
   parameter int NUM_PORTS = 4,
   parameter int MAX_PKT   = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic [NUM_PORTS*WIDTH-1:0] i_tdata,
   input  logic [NUM_PORTS-1:0]       i_tlast,
   input  logic [NUM_PORTS-1:0]       i_tvalid,
   output logic [NUM_PORTS-1:0]       i_tready,
   input  logic [15:0]                fifo_space,
   output logic [WIDTH-1:0]           o_tdata,
   output logic                       o_tlast,
   output logic                       o_tvalid,
   input  logic                       o_tready,
   output logic [NUM_PORTS-1:0]       grant,
   output logic [15:0]                pkt_count,
   output logic [15:0]                trunc_count
);

   localparam int SEL_W = $clog2(NUM_PORTS);
   localparam int CNT_W = $clog2(MAX_PKT + 1);
   localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(MAX_PKT - 1);
   localparam logic [15:0]          SPACE_MIN = 16'(MAX_PKT);
   localparam logic [SEL_W-1:0]     LAST_PORT = SEL_W'(NUM_PORTS - 1);
   localparam logic [NUM_PORTS-1:0] ONE_HOT0  = NUM_PORTS'(1);

   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [SEL_W-1:0]     last_q, last_d;
   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [15:0]          pkt_cnt_q, pkt_cnt_d;
   logic [15:0]          trunc_cnt_q, trunc_cnt_d;

   logic [WIDTH-1:0]     port_data_s [NUM_PORTS];
   logic [SEL_W:0]       arb_pick_s;
   logic [WIDTH-1:0]     sel_data_s;
   logic                 sel_valid_s;
   logic                 sel_last_s;
   logic                 at_limit_s;

   // Returns {found, index} of the first requester after 'last', wrapping modulo NUM_PORTS.
   function automatic logic [SEL_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [SEL_W-1:0]     last);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] pidx;
      int               sum;
      res = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         sum  = int'(last) + k;
         pidx = (sum >= NUM_PORTS) ? SEL_W'(sum - NUM_PORTS) : SEL_W'(sum);
         if (req[pidx]) begin
            res = {1'b1, pidx};
         end
      end
      return res;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   for (genvar n = 0; n < NUM_PORTS; n++) begin : g_unpack
      assign port_data_s[n] = i_tdata[n*WIDTH +: WIDTH];
   end

   assign arb_pick_s  = rr_pick(i_tvalid, last_q);
   assign sel_data_s  = port_data_s[sel_q];
   assign sel_valid_s = i_tvalid[sel_q];
   assign sel_last_s  = i_tlast[sel_q];
   assign at_limit_s  = (beat_cnt_q == LAST_BEAT);

   // Next-state logic and the combinational pass-through datapath.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_d      = last_q;
      beat_cnt_d  = beat_cnt_q;
      grant_d     = grant_q;
      pkt_cnt_d   = pkt_cnt_q;
      trunc_cnt_d = trunc_cnt_q;
      i_tready    = '0;
      o_tvalid    = 1'b0;
      o_tlast     = 1'b0;
      o_tdata     = sel_data_s;

      case (state_q)
         ST_ARB: begin
            if (arb_pick_s[SEL_W] && (fifo_space >= SPACE_MIN)) begin
               sel_d      = arb_pick_s[SEL_W-1:0];
               grant_d    = ONE_HOT0 << arb_pick_s[SEL_W-1:0];
               beat_cnt_d = '0;
               state_d    = ST_PASS;
            end else begin
               grant_d    = '0;
            end
         end
         ST_PASS: begin
            o_tvalid        = sel_valid_s;
            o_tlast         = sel_last_s | at_limit_s;
            i_tready[sel_q] = o_tready;
            if (sel_valid_s && o_tready) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               // A genuine tlast on the limit beat is a normal end, not a truncation.
               if (sel_last_s) begin
                  pkt_cnt_d = pkt_cnt_q + 16'd1;
                  last_d    = sel_q;
                  grant_d   = '0;
                  state_d   = ST_ARB;
               end else if (at_limit_s) begin
                  pkt_cnt_d   = pkt_cnt_q + 16'd1;
                  trunc_cnt_d = sat_inc16(trunc_cnt_q);
                  state_d     = ST_DROP;
               end else begin
                  state_d = ST_PASS;
               end
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
         end
         ST_DROP: begin
            i_tready[sel_q] = 1'b1;
            if (sel_valid_s && sel_last_s) begin
               last_d  = sel_q;
               grant_d = '0;
               state_d = ST_ARB;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_ARB;
         end
      endcase
   end

   // State register; clear behaves exactly like reset.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q     <= ST_ARB;
         sel_q       <= '0;
         last_q      <= LAST_PORT;
         beat_cnt_q  <= '0;
         grant_q     <= '0;
         pkt_cnt_q   <= 16'd0;
         trunc_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         beat_cnt_q  <= beat_cnt_d;
         grant_q     <= grant_d;
         pkt_cnt_q   <= pkt_cnt_d;
         trunc_cnt_q <= trunc_cnt_d;
      end
   end

   assign grant       = grant_q;
   assign pkt_count   = pkt_cnt_q;
   assign trunc_count = trunc_cnt_q;

endmodule

// File: tb/tb_axi_fifo_pkt_arb.sv
// Directed bench for axi_fifo_pkt_arb: per-port source queues feed the DUT and an
// expected-output scoreboard is filled when packets are queued and drained on output beats.
module tb_axi_fifo_pkt_arb;

   localparam int W  = 32;
   localparam int NP = 4;
   localparam int MP = 64;

   logic            clk = 1'b0;
   logic            reset, clear;
   logic [NP*W-1:0] i_tdata;
   logic [NP-1:0]   i_tlast, i_tvalid, i_tready;
   logic [15:0]     fifo_space;
   logic [W-1:0]    o_tdata;
   logic            o_tlast, o_tvalid, o_tready;
   logic [NP-1:0]   grant;
   logic [15:0]     pkt_count, trunc_count;

   always #5 clk = ~clk;

   axi_fifo_pkt_arb #(.WIDTH(W), .NUM_PORTS(NP), .MAX_PKT(MP)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .fifo_space(fifo_space),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .grant(grant), .pkt_count(pkt_count), .trunc_count(trunc_count)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [W:0]    srcq [NP][$];
   logic [W:0]    expq [$];
   int            out_beats  = 0;
   int            drop_beats = 0;
   int            exp_pkts   = 0;
   int            zero_run   = 0;
   logic          gap_chk    = 1'b0;
   logic          ordy       = 1'b1;
   logic [15:0]   space      = 16'd512;
   logic [NP-1:0] smp_grant, smp_iready;
   logic          smp_ovalid;
   logic [W-1:0]  smp_odata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      logic [W:0] h;
      for (int p = 0; p < NP; p++) begin
         if (srcq[p].size() > 0) begin
            h                = srcq[p][0];
            i_tvalid[p]      = 1'b1;
            i_tdata[p*W +: W] = h[W-1:0];
            i_tlast[p]       = h[W];
         end else begin
            i_tvalid[p]      = 1'b0;
            i_tdata[p*W +: W] = '0;
            i_tlast[p]       = 1'b0;
         end
      end
      o_tready   = ordy;
      fifo_space = space;
   endtask

   // Queue a packet of n words at a port; the first nexp words are expected out,
   // with tlast forced on word nexp when trunc is set.
   task automatic send(input int p, input int n, input logic [W-1:0] base,
                       input int nexp, input logic trunc);
      logic       l;
      logic [W-1:0] d;
      for (int i = 1; i <= n; i++) begin
         d = base + W'(i);
         l = (i == n);
         srcq[p].push_back({l, d});
         if (i <= nexp) begin
            l = (i == n) || (trunc && (i == nexp));
            expq.push_back({l, d});
         end
      end
   endtask

   function automatic int pending();
      int s;
      s = expq.size();
      for (int p = 0; p < NP; p++) s += srcq[p].size();
      return s;
   endfunction

   task automatic cycle();
      logic [W:0] e;
      @(negedge clk);
      smp_grant  = grant;
      smp_iready = i_tready;
      smp_ovalid = o_tvalid;
      smp_odata  = o_tdata;
      if (o_tvalid && o_tready) begin
         out_beats++;
         chk("beat_expected", 64'(expq.size() != 0), 64'd1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("o_tdata", 64'(o_tdata), 64'(e[W-1:0]));
            chk("o_tlast", 64'(o_tlast), 64'(e[W]));
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (i_tvalid[p] && i_tready[p]) begin
            if (!o_tvalid) drop_beats++;
            if (srcq[p].size() > 0) void'(srcq[p].pop_front());
         end
      end
      if (gap_chk) begin
         if ((grant == '0) && (|i_tvalid)) begin
            zero_run++;
         end else if (grant != '0) begin
            if (zero_run > 0) chk("arb_gap", 64'(zero_run), 64'd1);
            zero_run = 0;
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_idle(input int budget);
      int n = 0;
      while ((pending() > 0) && (n < budget)) begin
         cycle();
         n++;
      end
      chk("drain_pending", 64'(pending()), 64'd0);
      cycle();
   endtask

   task automatic wait_beats(input int target, input int budget);
      int n = 0;
      while ((out_beats < target) && (n < budget)) begin
         cycle();
         n++;
      end
      chk("wait_beats", 64'(out_beats), 64'(target));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int p = 0; p < NP; p++) srcq[p].delete();
      expq.delete();
      drive();
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      exp_pkts = 0;
   endtask

   initial begin
      int base;
      reset    = 1'b1;
      clear    = 1'b0;
      i_tdata  = '0;
      i_tlast  = '0;
      i_tvalid = '0;
      drive();
      do_reset();

      // Reset state
      cycle();
      chk("rst_grant", 64'(smp_grant), 64'd0);
      chk("rst_iready", 64'(smp_iready), 64'd0);
      chk("rst_ovalid", 64'(smp_ovalid), 64'd0);
      chk("rst_pkt", 64'(pkt_count), 64'd0);
      chk("rst_trunc", 64'(trunc_count), 64'd0);

      // 1: single 4-word packet on port0
      space = 16'd512;
      send(0, 4, 32'd0, 4, 1'b0);
      exp_pkts++;
      drive();
      cycle();
      chk("t1_grant_arb", 64'(smp_grant), 64'd0);
      chk("t1_grant", 64'(grant), 64'b0001);
      run_idle(40);
      chk("t1_pkt", 64'(pkt_count), 64'(exp_pkts));
      chk("t1_back_arb", 64'(grant), 64'd0);

      // 2: all ports busy, round-robin order 0,1,2,3,0,1
      do_reset();
      for (int p = 0; p < NP; p++) send(p, 2, W'((p << 8) | (1 << 4)), 0, 1'b0);
      send(0, 2, 32'h0020, 0, 1'b0);
      send(1, 2, 32'h0120, 0, 1'b0);
      for (int p = 0; p < NP; p++) send(NP, 0, 32'd0, 0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         base = ((k % NP) << 8) | ((k < NP ? 1 : 2) << 4);
         expq.push_back({1'b0, W'(base + 1)});
         expq.push_back({1'b1, W'(base + 2)});
         exp_pkts++;
      end
      gap_chk  = 1'b1;
      zero_run = 0;
      drive();
      run_idle(100);
      gap_chk = 1'b0;
      chk("t2_pkt", 64'(pkt_count), 64'(exp_pkts));

      // 3: space one short of MAX_PKT blocks the grant
      space = 16'(MP - 1);
      send(2, 2, 32'h0300, 2, 1'b0);
      exp_pkts++;
      drive();
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("t3_no_grant", 64'(smp_grant), 64'd0);
      end
      space = 16'(MP);
      drive();
      cycle();
      chk("t3_grant", 64'(grant), 64'b0100);
      run_idle(40);

      // 4: 70-word packet truncated to MAX_PKT, tail discarded
      base = drop_beats;
      send(1, 70, 32'h4000, MP, 1'b1);
      exp_pkts++;
      drive();
      run_idle(200);
      chk("t4_dropped", 64'(drop_beats - base), 64'd6);
      chk("t4_trunc", 64'(trunc_count), 64'd1);
      chk("t4_pkt", 64'(pkt_count), 64'(exp_pkts));

      // 5: downstream stall on beats 3..5
      send(2, 8, 32'h0500, 8, 1'b0);
      exp_pkts++;
      drive();
      wait_beats(out_beats + 2, 50);
      ordy = 1'b0;
      drive();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t5_hold_data", 64'(smp_odata), 64'h503);
         chk("t5_hold_valid", 64'(smp_ovalid), 64'd1);
         chk("t5_no_ready", 64'(smp_iready), 64'd0);
      end
      ordy = 1'b1;
      drive();
      run_idle(40);
      chk("t5_trunc", 64'(trunc_count), 64'd1);
      chk("t5_pkt", 64'(pkt_count), 64'(exp_pkts));

      // 6: clear mid-packet, then port0 wins over port3
      send(3, 6, 32'h0600, 3, 1'b0);
      drive();
      wait_beats(out_beats + 2, 50);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      chk("t6_grant", 64'(grant), 64'd0);
      chk("t6_pkt", 64'(pkt_count), 64'd0);
      chk("t6_trunc", 64'(trunc_count), 64'd0);
      srcq[3].delete();
      exp_pkts = 0;
      drive();
      cycle();
      chk("t6_ovalid", 64'(smp_ovalid), 64'd0);
      send(0, 2, 32'h0700, 2, 1'b0);
      send(3, 2, 32'h0730, 2, 1'b0);
      exp_pkts += 2;
      drive();
      cycle();
      chk("t6_first_grant", 64'(grant), 64'b0001);
      run_idle(40);
      chk("t6_pkt_end", 64'(pkt_count), 64'(exp_pkts));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_fifo_pkt_arb.md
Name: axi_fifo_pkt_arb

Overview:
Round-robin, packet-granular arbiter that shares one axi_fifo_bram write port between NUM_PORTS AXI-stream requesters. It grants a port only when the FIFO's reported space can absorb a worst-case packet. It holds the grant until that packet's tlast, so packets are never interleaved. Packets longer than MAX_PKT are truncated, and the remainder is discarded, so the space guarantee always holds.

Parameters:
WIDTH, 32, data width of every stream.
NUM_PORTS, 4, number of requesters; 2..16.
MAX_PKT, 64, maximum words forwarded per packet; 1..32768.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous soft reset; same effect as reset
i_tdata  in  NUM_PORTS*WIDTH  port n occupies bits [n*WIDTH +: WIDTH]
i_tlast  in  NUM_PORTS  per-port end of packet
i_tvalid  in  NUM_PORTS  per-port valid
i_tready  out  NUM_PORTS  per-port ready
fifo_space  in  16  space output of the downstream FIFO
o_tdata  out  WIDTH  to FIFO i_tdata
o_tlast  out  1  end of forwarded packet
o_tvalid  out  1  to FIFO i_tvalid
o_tready  in  1  from FIFO i_tready
grant  out  NUM_PORTS  one-hot owner; all zero in ST_ARB
pkt_count  out  16  packets forwarded; wraps
trunc_count  out  16  packets truncated; saturates at 0xFFFF

Behaviour:
- Reset/clear: state=ST_ARB, last=NUM_PORTS-1, beat_cnt=0, both counts 0, grant=0, i_tready=0, o_tvalid=0. Clear has lower priority than reset and identical effect. Clear mid-packet abandons the packet; the FIFO is cleared alongside it.
- State ST_ARB:
  - Grant condition: |i_tvalid and fifo_space >= MAX_PKT (unsigned 16-bit compare).
  - Port chosen: the first port with valid set, searching last+1, last+2, ... modulo NUM_PORTS.
  - Registered actions: sel, grant=onehot(sel), beat_cnt=0, next state ST_PASS.
  - No data moves in ST_ARB, so arbitration costs 1 cycle per packet.
- State ST_PASS (combinational datapath):
  - o_tdata = i_tdata[sel] and o_tvalid = i_tvalid[sel].
  - i_tready[sel] = o_tready; all other ports have i_tready=0.
  - o_tlast = i_tlast[sel] | (beat_cnt == MAX_PKT-1).
  - A beat is o_tvalid & o_tready; each beat increments beat_cnt.
  - Beat with i_tlast=1: pkt_count++, last=sel, state -> ST_ARB.
  - Beat with beat_cnt==MAX_PKT-1 and i_tlast=0: forced tlast is emitted, pkt_count++, trunc_count++ (saturating), state -> ST_DROP.
  - When both conditions hold on the same beat, i_tlast wins: no truncation is counted.
- State ST_DROP:
  - o_tvalid=0 and i_tready[sel]=1 regardless of o_tready.
  - Input beats are discarded; on a beat with i_tlast: last=sel, state -> ST_ARB.
- Bubbles: a deasserted i_tvalid mid-packet holds the grant indefinitely; no timeout.
- Fairness: a port waits at most NUM_PORTS-1 packets once the space condition is met.
- Timing: grant and state are registered; the datapath is purely combinational. No output register, so FIFO latency is unchanged.
- Width rules: beat_cnt is clog2(MAX_PKT+1) bits. fifo_space is trusted as-is; its diagnostic inexactness is absorbed by the worst-case MAX_PKT check.

Test Plan:
1. Port0 sends a 4-word packet (data 1..4), fifo_space=512, o_tready=1 -> grant=0001 one cycle after valid; 4 beats out, o_tlast on data 4; pkt_count=1; back in ST_ARB.
2. All 4 ports continuously valid with 2-word packets -> packet order 0,1,2,3,0,1; no interleaved words; grant=0 for exactly 1 cycle between packets.
3. MAX_PKT=64: fifo_space=63 with port2 valid -> no grant for 20 cycles; fifo_space=64 -> grant=0100 on the next edge.
4. Port1 sends 70 words, MAX_PKT=64 -> 64 words out with o_tlast on word 64; words 65..70 consumed with o_tvalid=0; trunc_count=1, pkt_count=1.
5. 8-word packet with o_tready low on beats 3-5 -> o_tdata holds word 3 and i_tready[sel]=0 while low; all 8 words delivered in order; beat_cnt unaffected by stalls.
6. Clear asserted at word 3 of a port3 packet -> next cycle grant=0, o_tvalid=0, counts=0; with ports 0 and 3 then valid, port0 is granted first.
